// File: rtl/time_preset.sv
`default_nettype none
// ============================================================================
//  Module      : time_preset
//  Description : MM:SS preset entry for the countdown timer. MODE steps
//                IDLE -> SET_MIN -> SET_SEC -> IDLE; INC (edge + auto-repeat)
//                counts the selected BCD field up. Leaving SET_SEC emits a
//                one-cycle LOAD strobe for the down-counter chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_preset #(
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 2,
    parameter int CNT_BITS     = 8
) (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       tick_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    output logic [3:0] m1_o,
    output logic [3:0] m0_o,
    output logic [3:0] s1_o,
    output logic [3:0] s0_o,
    output logic       edit_min_o,
    output logic       edit_sec_o,
    output logic       load_o,
    output logic       zero_o
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_set_min = 2'd1;
    localparam logic [1:0] c_set_sec = 2'd2;

    localparam logic [CNT_BITS-1:0] c_delay = CNT_BITS'(REPEAT_DELAY);
    localparam logic [CNT_BITS-1:0] c_rate  = CNT_BITS'(REPEAT_RATE);
    localparam logic [CNT_BITS-1:0] c_one   = CNT_BITS'(1);

    logic [1:0]          state_q, state_d;
    logic                load_q, load_d;
    logic                inc_q;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                rep_q, rep_d;
    logic [3:0]          m1_q, m0_q, s1_q, s0_q;
    logic [3:0]          m1_d, m0_d, s1_d, s0_d;
    logic                w_inc_ev;
    logic                w_edit;
    logic [CNT_BITS-1:0] w_cnt_inc;

    assign w_edit    = (state_q == c_set_min) || (state_q == c_set_sec);
    assign w_cnt_inc = cnt_q + c_one;

    // Field FSM: every MODE pulse advances the state; the SET_SEC exit loads.
    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        if (btn_mode_i) begin
            case (state_q)
                c_idle:    state_d = c_set_min;
                c_set_min: state_d = c_set_sec;
                c_set_sec: begin
                    state_d = c_idle;
                    load_d  = 1'b1;
                end
                default:   state_d = c_idle;
            endcase
        end
    end

    // Increment source: INC rising edge, then delayed and periodic auto-repeat.
    // A MODE pulse wins over any increment and restarts the repeat timing.
    always_comb begin
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        w_inc_ev = 1'b0;
        if (!w_edit || btn_mode_i || !btn_inc_i) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (!inc_q) begin
            cnt_d    = '0;
            w_inc_ev = 1'b1;
        end else if (tick_i) begin
            if (w_cnt_inc == (rep_q ? c_rate : c_delay)) begin
                cnt_d    = '0;
                rep_d    = 1'b1;
                w_inc_ev = 1'b1;
            end else begin
                cnt_d = w_cnt_inc;
            end
        end
    end

    // BCD increment of the selected field only: minutes wrap 99->00, seconds 59->00.
    always_comb begin
        m1_d = m1_q;
        m0_d = m0_q;
        s1_d = s1_q;
        s0_d = s0_q;
        if (w_inc_ev && state_q == c_set_min) begin
            if (m0_q == 4'd9) begin
                m0_d = 4'd0;
                m1_d = (m1_q == 4'd9) ? 4'd0 : m1_q + 4'd1;
            end else begin
                m0_d = m0_q + 4'd1;
            end
        end else if (w_inc_ev && state_q == c_set_sec) begin
            if (s0_q == 4'd9) begin
                s0_d = 4'd0;
                s1_d = (s1_q == 4'd5) ? 4'd0 : s1_q + 4'd1;
            end else begin
                s0_d = s0_q + 4'd1;
            end
        end
    end

    // State, digit and repeat registers with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= c_idle;
            load_q  <= 1'b0;
            inc_q   <= 1'b0;
            cnt_q   <= '0;
            rep_q   <= 1'b0;
            m1_q    <= 4'd0;
            m0_q    <= 4'd0;
            s1_q    <= 4'd0;
            s0_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            inc_q   <= btn_inc_i;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            m1_q    <= m1_d;
            m0_q    <= m0_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
        end
    end

    assign m1_o       = m1_q;
    assign m0_o       = m0_q;
    assign s1_o       = s1_q;
    assign s0_o       = s0_q;
    assign edit_min_o = (state_q == c_set_min);
    assign edit_sec_o = (state_q == c_set_sec);
    assign load_o     = load_q;
    assign zero_o     = (m1_q == 4'd0) && (m0_q == 4'd0) && (s1_q == 4'd0) && (s0_q == 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_time_preset.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_preset
//  Description : Directed self-checking bench for time_preset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_preset;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] m1, m0, s1, s0;
    logic       edit_min, edit_sec, load, zero;

    int n_tests = 0;
    int n_fail  = 0;

    time_preset #(
        .REPEAT_DELAY(8),
        .REPEAT_RATE (2),
        .CNT_BITS    (8)
    ) dut (
        .clk_i      (clk),
        .clr_i      (clr),
        .tick_i     (tick),
        .btn_mode_i (btn_mode),
        .btn_inc_i  (btn_inc),
        .m1_o       (m1),
        .m0_o       (m0),
        .s1_o       (s1),
        .s0_o       (s0),
        .edit_min_o (edit_min),
        .edit_sec_o (edit_sec),
        .load_o     (load),
        .zero_o     (zero)
    );

    always #5 clk = ~clk;

    // One clock: inputs set beforehand are sampled at this edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {m1, m0, s1, s0};
    endfunction

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1;
            cycle();
            btn_inc = 1'b0;
            cycle();
        end
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        cycle();
        btn_mode = 1'b0;
    endtask

    task automatic one_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
    endtask

    initial begin
        // Reset
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("rst_digits", digits(), 16'h0000);
        check("rst_flags", {12'd0, edit_min, edit_sec, load, zero}, 16'h0001);

        // IDLE -> SET_MIN
        press_mode();
        check("mode_min_flags", {12'd0, edit_min, edit_sec, load, zero}, 16'h0009);
        check("mode_min_digits", digits(), 16'h0000);

        // Single edge: one-cycle latency
        btn_inc = 1'b1;
        cycle();
        check("inc_latency", digits(), 16'h0100);
        btn_inc = 1'b0;
        cycle();
        press_inc(9);
        check("min_10", digits(), 16'h1000);
        check("zero_low", {15'd0, zero}, 16'h0000);
        press_inc(89);
        check("min_99", digits(), 16'h9900);
        press_inc(1);
        check("min_wrap", digits(), 16'h0000);
        check("zero_after_wrap", {15'd0, zero}, 16'h0001);
        press_inc(5);
        check("min_05", digits(), 16'h0500);

        // SET_SEC
        press_mode();
        check("mode_sec_flags", {12'd0, edit_min, edit_sec, load, zero}, 16'h0004);
        press_inc(58);
        check("sec_58", digits(), 16'h0558);
        press_inc(1);
        check("sec_59", digits(), 16'h0559);
        press_inc(1);
        check("sec_wrap", digits(), 16'h0500);

        // Auto-repeat: edge, then TICK 8, 10, 12, 14
        btn_inc = 1'b1;
        cycle();
        check("rep_edge", digits(), 16'h0501);
        for (int i = 0; i < 7; i++) one_tick();
        check("rep_tick7", digits(), 16'h0501);
        one_tick();
        check("rep_tick8", digits(), 16'h0502);
        one_tick();
        check("rep_tick9", digits(), 16'h0502);
        for (int i = 0; i < 4; i++) one_tick();
        check("rep_tick13", digits(), 16'h0504);
        one_tick();
        check("rep_tick14", digits(), 16'h0505);
        btn_inc = 1'b0;
        cycle();
        one_tick();
        check("rep_release", digits(), 16'h0505);

        // Set 05:30 and leave edit mode
        press_inc(25);
        check("sec_30", digits(), 16'h0530);
        check("preload_no_load", {15'd0, load}, 16'h0000);
        press_mode();
        check("load_strobe", {12'd0, edit_min, edit_sec, load, zero}, 16'h0002);
        check("load_digits", digits(), 16'h0530);
        cycle();
        check("load_one_cycle", {15'd0, load}, 16'h0000);
        press_inc(2);
        check("idle_inc_ignored", digits(), 16'h0530);

        // MODE coincident with INC edge in SET_MIN
        press_mode();
        check("reenter_min", {12'd0, edit_min, edit_sec, load, zero}, 16'h0008);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        cycle();
        btn_mode = 1'b0;
        check("coincide_state", {12'd0, edit_min, edit_sec, load, zero}, 16'h0004);
        check("coincide_digits", digits(), 16'h0530);
        cycle();
        check("held_on_entry", digits(), 16'h0530);
        btn_inc = 1'b0;
        cycle();

        // Reset mid-SET_SEC
        press_inc(1);
        check("sec_31", digits(), 16'h0531);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("clr_digits", digits(), 16'h0000);
        check("clr_flags", {12'd0, edit_min, edit_sec, load, zero}, 16'h0001);
        cycle();
        check("clr_no_load", {15'd0, load}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
